seg_display_scanner: RTL and testbench

//   Producer end of the BCD-digit -> seven-segment decoder interface.
//   - Accepts a binary value (e.g. credit or price) and converts it to BCD with a sequential

---
 rtl/seg_display_scanner_pkg.sv | 28 ++
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 rtl/seg_display_scanner.sv | 128 ++++++++++++
 tb/tb_seg_display_scanner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_scanner_pkg
//   Shared definitions for the seven-segment display scanner:
//   - conv_state_e : state codes of the binary-to-BCD conversion FSM
//   - BLANK_CODE   : digit-bus code that the segment decoder renders as all off
//   - max_value()  : largest value that fits in a given number of decimal digits
// -----------------------------------------------------------------------------
package seg_display_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // 10**num_digits - 1; evaluated at elaboration, fits 32 bits for up to 9 digits.
    function automatic int unsigned max_value(input int unsigned num_digits);
        int unsigned result;
        result = 1;
        for (int unsigned i = 0; i < num_digits; i++) begin
            result = result * 10;
        end
        return result - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential double-dabble converter. A load in IDLE captures the operand
//   (saturated to the largest NUM_DIGITS-digit decimal value), then BIN_WIDTH
//   SHIFT cycles build the BCD result, then one DONE cycle presents it.
//
// Ports
//   clk       in   1              rising-edge clock
//   rst       in   1              asynchronous reset, active-high
//   load      in   1              start strobe, honoured only while idle
//   bin_in    in   BIN_WIDTH      binary operand
//   busy      out  1              registered; high in SHIFT and DONE
//   done      out  1              registered; high for the single DONE cycle
//   bcd_out   out  4*NUM_DIGITS   BCD result, valid while done is high
//   overflow  out  1              operand was saturated, valid while done is high
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import seg_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [BIN_WIDTH-1:0]      bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic                      overflow
);

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam int unsigned MAX_VAL = max_value(NUM_DIGITS);
    // Comparison width wide enough for both the operand and the decimal limit.
    localparam int          CMP_W   = (BIN_WIDTH > 32) ? BIN_WIDTH : 32;

    localparam logic [CNT_W-1:0]     LAST_COUNT = CNT_W'(BIN_WIDTH - 1);
    // Only used when saturating, which implies MAX_VAL fits in BIN_WIDTH bits.
    localparam logic [BIN_WIDTH-1:0] MAX_BIN    = BIN_WIDTH'(MAX_VAL);

    conv_state_e            state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic                   saturate;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        count_d    = count_q;
        ovf_pend_d = ovf_pend_q;

        saturate = (CMP_W'(bin_in) > CMP_W'(MAX_VAL));

        // Add-3 correction: any nibble >= 5 would exceed 9 after doubling.
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d    = ST_SHIFT;
                    bcd_d      = '0;
                    count_d    = LAST_COUNT;
                    bin_d      = saturate ? MAX_BIN : bin_in;
                    ovf_pend_d = saturate;
                end
            end
            ST_SHIFT: begin
                // The bit shifted out of the top nibble is always zero because
                // the operand never exceeds the decimal limit.
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                count_d        = count_q - CNT_W'(1);
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the values
            // that existed before this edge regardless of statement order.
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            count_q    <= count_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_pend_q;

endmodule

// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//   Converts a binary value to BCD and time-multiplexes the digits onto a
//   shared BCD digit bus with active-low one-hot digit selects.
//
// Ports
//   clk         in   1             rising-edge clock
//   rst         in   1             asynchronous reset, active-high
//   value_in    in   BIN_WIDTH     binary value to display
//   value_load  in   1             capture strobe, ignored while busy
//   busy        out  1             conversion in progress
//   overflow    out  1             last loaded value was saturated
//   digit       out  4             BCD digit to the decoder, 4'hF = blank
//   digit_sel   out  NUM_DIGITS    active-low digit enable, bit 0 = LSD
// -----------------------------------------------------------------------------
module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int BIN_WIDTH     = 14,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BIN_WIDTH-1:0]   value_in,
    input  logic                   value_load,
    output logic                   busy,
    output logic                   overflow,
    output logic [3:0]             digit,
    output logic [NUM_DIGITS-1:0]  digit_sel
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

    logic                   conv_busy;
    logic                   conv_done;
    logic [BCD_W-1:0]       conv_bcd;
    logic                   conv_ovf;

    logic [BCD_W-1:0]       display_q, display_d;
    logic                   overflow_q, overflow_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [3:0]             digit_q, digit_d;
    logic [NUM_DIGITS-1:0]  sel_q, sel_d;

    logic                   tick;
    logic                   zero_from_top;
    logic [NUM_DIGITS-1:0]  blank_vec;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_WIDTH  (BIN_WIDTH)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .load     (value_load),
        .bin_in   (value_in),
        .busy     (conv_busy),
        .done     (conv_done),
        .bcd_out  (conv_bcd),
        .overflow (conv_ovf)
    );

    always_comb begin
        // Display and overflow change only on the DONE edge: no partial update.
        display_d  = conv_done ? conv_bcd : display_q;
        overflow_d = conv_done ? conv_ovf : overflow_q;

        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);

        index_d = index_q;
        if (tick) begin
            index_d = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);
        end

        // Blanking looks at display_d so a DONE coinciding with a tick shows
        // the new value. A digit is blank when it and everything above it is 0;
        // digit 0 is never blanked so zero displays as "0".
        zero_from_top = 1'b1;
        blank_vec     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from_top = zero_from_top && (display_d[4*i +: 4] == 4'd0);
            if ((i > 0) && (BLANK_LEADING != 0)) begin
                blank_vec[i] = zero_from_top;
            end
        end

        // Outputs are loaded only on a tick, from the already-advanced index.
        digit_d = digit_q;
        sel_d   = sel_q;
        if (tick) begin
            sel_d   = ~(NUM_DIGITS'(1) << index_d);
            digit_d = blank_vec[index_d] ? BLANK_CODE : display_d[4*index_d +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display_q  <= '0;
            overflow_q <= 1'b0;
            presc_q    <= '0;
            index_q    <= '0;
            digit_q    <= BLANK_CODE;
            sel_q      <= '1;
        end else begin
            display_q  <= display_d;
            overflow_q <= overflow_d;
            presc_q    <= presc_d;
            index_q    <= index_d;
            digit_q    <= digit_d;
            sel_q      <= sel_d;
        end
    end

    assign busy      = conv_busy;
    assign overflow  = overflow_q;
    assign digit     = digit_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//   Self-checking bench for seg_display_scanner with NUM_DIGITS=4,
//   BIN_WIDTH=14, REFRESH_DIV=4. Two instances share all inputs: one blanks
//   leading zeros, the other shows every digit.
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] value_in = '0;
    logic          value_load = 1'b0;

    logic          busy_b, ovf_b, busy_n, ovf_n;
    logic [3:0]    digit_b, digit_n;
    logic [ND-1:0] sel_b, sel_n;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .value_load(value_load),
        .busy(busy_b), .overflow(ovf_b), .digit(digit_b), .digit_sel(sel_b)
    );

    seg_display_scanner #(
        .NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD), .BLANK_LEADING(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .value_in(value_in), .value_load(value_load),
        .busy(busy_n), .overflow(ovf_n), .digit(digit_n), .digit_sel(sel_n)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard of expected scan steps, index 0 first.
    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] dig_b;
        logic [3:0] dig_n;
    } scan_exp_t;

    scan_exp_t sb_q[$];

    typedef struct {
        int unsigned value;
        logic        exp_ovf;
        logic [15:0] exp_blank;   // nibble i = expected digit at index i, blanking on
    } vec_t;

    // Decimal digit of the saturated value, no blanking.
    function automatic logic [3:0] plain_digit(input int unsigned v, input int idx);
        int unsigned s;
        s = (v > 9999) ? 9999 : v;
        for (int k = 0; k < idx; k++) s = s / 10;
        return 4'(s % 10);
    endfunction

    task automatic push_scan(input logic [15:0] exp_blank, input int unsigned v);
        scan_exp_t  e;
        logic [3:0] s;
        for (int i = 0; i < ND; i++) begin
            s       = 4'b0001 << i;
            e.sel   = ~s;
            e.dig_b = exp_blank[4*i +: 4];
            e.dig_n = plain_digit(v, i);
            sb_q.push_back(e);
        end
    endtask

    // Waits for the start of a fresh index-0 tick, then compares four ticks.
    task automatic check_scan(input string name);
        int        n;
        scan_exp_t e;
        n = 0;
        while (sel_b == 4'b1110 && n < 50) begin @(negedge clk); n++; end
        while (sel_b != 4'b1110 && n < 50) begin @(negedge clk); n++; end
        check({name, "_scan_timeout"}, (n >= 50), 0);
        if (n >= 50) begin
            sb_q.delete();
            return;
        end
        for (int i = 0; i < ND; i++) begin
            e = sb_q.pop_front();
            check($sformatf("%s_sel%0d", name, i), sel_b, e.sel);
            check($sformatf("%s_dig%0d", name, i), digit_b, e.dig_b);
            check($sformatf("%s_nb_sel%0d", name, i), sel_n, e.sel);
            check($sformatf("%s_nb_dig%0d", name, i), digit_n, e.dig_n);
            repeat (RD) @(negedge clk);
        end
    endtask

    // Loads v and counts busy cycles; optionally strobes a second load at
    // busy cycle inject_at (0 = none).
    task automatic load_value(input int unsigned v, input int inject_at,
                              input int unsigned inject_val, output int busy_cycles);
        @(negedge clk);
        value_in   = BW'(v);
        value_load = 1'b1;
        @(posedge clk);
        #1;
        check("busy_rise", busy_b, 1);
        @(negedge clk);
        value_load  = 1'b0;
        busy_cycles = 0;
        for (int n = 0; n < 100 && busy_b; n++) begin
            busy_cycles++;
            if (inject_at != 0 && busy_cycles == inject_at) begin
                value_in   = BW'(inject_val);
                value_load = 1'b1;
            end else begin
                value_load = 1'b0;
            end
            @(negedge clk);
        end
        value_load = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           bc;
        logic [3:0]   r_sel[4];
        logic [3:0]   r_dig_b[4];
        logic [3:0]   r_dig_n[4];

        vecs[0] = '{1234,  1'b0, 16'h1234};
        vecs[1] = '{7,     1'b0, 16'hFFF7};
        vecs[2] = '{12000, 1'b1, 16'h9999};
        vecs[3] = '{42,    1'b0, 16'hFF42};
        vecs[4] = '{0,     1'b0, 16'hFFF0};
        vecs[5] = '{9999,  1'b0, 16'h9999};
        vecs[6] = '{10000, 1'b1, 16'h9999};
        vecs[7] = '{1005,  1'b0, 16'h1005};
        vecs[8] = '{100,   1'b0, 16'hF100};
        vecs[9] = '{16383, 1'b1, 16'h9999};

        // 1. Reset values and release sequence.
        repeat (3) @(negedge clk);
        check("rst_sel", sel_b, 4'b1111);
        check("rst_dig", digit_b, 4'hF);
        check("rst_busy", busy_b, 0);
        check("rst_ovf", ovf_b, 0);
        check("rst_nb_sel", sel_n, 4'b1111);
        rst = 1'b0;
        r_sel   = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        r_dig_b = '{4'hF, 4'hF, 4'hF, 4'h0};
        r_dig_n = '{4'h0, 4'h0, 4'h0, 4'h0};
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c % RD != 0) begin
                if (c < RD) begin
                    check($sformatf("rel_pre_sel_c%0d", c), sel_b, 4'b1111);
                    check($sformatf("rel_pre_dig_c%0d", c), digit_b, 4'hF);
                end
            end else begin
                check($sformatf("rel_sel_c%0d", c), sel_b, r_sel[c/RD - 1]);
                check($sformatf("rel_dig_c%0d", c), digit_b, r_dig_b[c/RD - 1]);
                check($sformatf("rel_nb_dig_c%0d", c), digit_n, r_dig_n[c/RD - 1]);
            end
        end

        // 2-4. Table-driven loads.
        foreach (vecs[k]) begin
            load_value(vecs[k].value, 0, 0, bc);
            check($sformatf("v%0d_busy_len", vecs[k].value), bc, 15);
            check($sformatf("v%0d_ovf", vecs[k].value), ovf_b, vecs[k].exp_ovf);
            check($sformatf("v%0d_nb_ovf", vecs[k].value), ovf_n, vecs[k].exp_ovf);
            push_scan(vecs[k].exp_blank, vecs[k].value);
            check_scan($sformatf("v%0d", vecs[k].value));
        end

        // 5. Load while busy is dropped.
        load_value(500, 5, 999, bc);
        check("drop_busy_len", bc, 15);
        check("drop_ovf", ovf_b, 0);
        push_scan(16'hF500, 500);
        check_scan("drop");

        // 6. Reset mid-conversion.
        load_value(12000, 0, 0, bc);
        check("pre_rst_ovf", ovf_b, 1);
        @(negedge clk);
        value_in   = BW'(4321);
        value_load = 1'b1;
        @(negedge clk);
        value_load = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", busy_b, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy_b, 0);
        check("arst_sel", sel_b, 4'b1111);
        check("arst_dig", digit_b, 4'hF);
        check("arst_ovf", ovf_b, 0);
        check("arst_nb_sel", sel_n, 4'b1111);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_busy", busy_b, 0);
        check("post_rst_ovf", ovf_b, 0);
        push_scan(16'hFFF0, 0);
        check_scan("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
